// File: rtl/ptp_tod_clock.sv
// PTP time-of-day counter: 48-bit seconds, 30-bit ns, 16-bit fractional ns, advancing by a programmable period plus optional slew.
// Define PTP_TOD_PPS_EN to build the one-cycle second-rollover pulse on output_pps.
module ptp_tod_clock #(
    parameter int                     PERIOD_NS_W = 4,
    parameter logic [PERIOD_NS_W-1:0] PERIOD_NS   = 4'h6,
    parameter logic [15:0]            PERIOD_FNS  = 16'h6666
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [95:0]              input_ts_96,
    input  logic                     input_ts_96_valid,
    input  logic [PERIOD_NS_W-1:0]   input_period_ns,
    input  logic [15:0]              input_period_fns,
    input  logic                     input_period_valid,
    input  logic [PERIOD_NS_W+16:0]  input_adj,
    input  logic [15:0]              input_adj_count,
    input  logic                     input_adj_valid,
    output logic                     input_adj_active,
    output logic [95:0]              output_ts_96,
    output logic                     output_ts_step,
    output logic                     output_pps
);

    localparam int PW = PERIOD_NS_W + 16;
    localparam int AW = PERIOD_NS_W + 17;
    localparam int SW = PERIOD_NS_W + 18;
    localparam logic [46:0] NS_PER_S = {31'd1_000_000_000, 16'd0};

    logic [47:0]   s_q, s_d;
    logic [29:0]   ns_q, ns_d;
    logic [15:0]   fns_q, fns_d;
    logic [PW-1:0] period_q, period_d;
    logic [AW-1:0] adj_q, adj_d;
    logic [15:0]   adj_cnt_q, adj_cnt_d;
    logic          step_q;
    logic          active_q;

    logic [SW-1:0] adj_term;
    logic [SW-1:0] step_sum;
    logic [SW-1:0] step_clamped;
    logic [46:0]   inc;
    logic [46:0]   ovf;
    logic          rollover;
    logic          load_ok;
    logic          unused_ts_bits;

    assign unused_ts_bits = ^input_ts_96[47:46];

    always_comb begin
        adj_term     = (adj_cnt_q != 16'd0) ? {adj_q[AW-1], adj_q} : '0;
        step_sum     = {2'b00, period_q} + adj_term;
        // A net negative slew holds time rather than letting it run backwards.
        step_clamped = step_sum[SW-1] ? '0 : step_sum;
        inc          = {1'b0, ns_q, fns_q} + {{(47-SW){1'b0}}, step_clamped};
        // Borrow clear means the increment crossed one second.
        ovf          = inc - NS_PER_S;
        rollover     = ~ovf[46];
        load_ok      = input_ts_96_valid && (input_ts_96[45:16] < 30'd1_000_000_000);

        s_d   = s_q;
        ns_d  = inc[45:16];
        fns_d = inc[15:0];
        if (load_ok) begin
            s_d   = input_ts_96[95:48];
            ns_d  = input_ts_96[45:16];
            fns_d = input_ts_96[15:0];
        end else if (rollover) begin
            s_d   = s_q + 48'd1;
            ns_d  = ovf[45:16];
            fns_d = ovf[15:0];
        end

        period_d = period_q;
        if (input_period_valid) begin
            period_d = {input_period_ns, input_period_fns};
        end

        adj_d     = adj_q;
        adj_cnt_d = (adj_cnt_q != 16'd0) ? adj_cnt_q - 16'd1 : 16'd0;
        if (input_adj_valid) begin
            adj_d     = input_adj;
            adj_cnt_d = input_adj_count;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q       <= '0;
            ns_q      <= '0;
            fns_q     <= '0;
            period_q  <= {PERIOD_NS, PERIOD_FNS};
            adj_q     <= '0;
            adj_cnt_q <= '0;
            step_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            s_q       <= s_d;
            ns_q      <= ns_d;
            fns_q     <= fns_d;
            period_q  <= period_d;
            adj_q     <= adj_d;
            adj_cnt_q <= adj_cnt_d;
            step_q    <= load_ok;
            active_q  <= (adj_cnt_d != 16'd0);
        end
    end

`ifdef PTP_TOD_PPS_EN
    logic pps_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pps_q <= 1'b0;
        end else begin
            pps_q <= rollover && !load_ok;
        end
    end

    assign output_pps = pps_q;
`else
    assign output_pps = 1'b0;
`endif

    assign output_ts_96     = {s_q, 2'b00, ns_q, fns_q};
    assign output_ts_step   = step_q;
    assign input_adj_active = active_q;

endmodule

// File: tb/tb_ptp_tod_clock.sv
// Directed bench for ptp_tod_clock: reset, default period, loads, rollover, slew and clamp, async reset.
module tb_ptp_tod_clock;

    logic        clk;
    logic        rst;
    logic [95:0] input_ts_96;
    logic        input_ts_96_valid;
    logic [3:0]  input_period_ns;
    logic [15:0] input_period_fns;
    logic        input_period_valid;
    logic [20:0] input_adj;
    logic [15:0] input_adj_count;
    logic        input_adj_valid;
    logic        input_adj_active;
    logic [95:0] output_ts_96;
    logic        output_ts_step;
    logic        output_pps;

    int n_checks = 0;
    int n_fail   = 0;

    ptp_tod_clock dut (
        .clk                (clk),
        .rst                (rst),
        .input_ts_96        (input_ts_96),
        .input_ts_96_valid  (input_ts_96_valid),
        .input_period_ns    (input_period_ns),
        .input_period_fns   (input_period_fns),
        .input_period_valid (input_period_valid),
        .input_adj          (input_adj),
        .input_adj_count    (input_adj_count),
        .input_adj_valid    (input_adj_valid),
        .input_adj_active   (input_adj_active),
        .output_ts_96       (output_ts_96),
        .output_ts_step     (output_ts_step),
        .output_pps         (output_pps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] ts(input logic [47:0] s, input logic [29:0] ns, input logic [15:0] fns);
        return {s, 2'b00, ns, fns};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_flags(input string tag, input logic step, input logic pps, input logic act);
        check_eq({tag, "_step"}, {95'd0, output_ts_step}, {95'd0, step});
        check_eq({tag, "_pps"}, {95'd0, output_pps}, {95'd0, pps});
        check_eq({tag, "_active"}, {95'd0, input_adj_active}, {95'd0, act});
    endtask

    logic pps_exp;

    initial begin
`ifdef PTP_TOD_PPS_EN
        pps_exp = 1'b1;
`else
        pps_exp = 1'b0;
`endif
        rst                = 1'b0;
        input_ts_96        = '0;
        input_ts_96_valid  = 1'b0;
        input_period_ns    = '0;
        input_period_fns   = '0;
        input_period_valid = 1'b0;
        input_adj          = '0;
        input_adj_count    = '0;
        input_adj_valid    = 1'b0;

        #3;
        check_eq("rst_ts", output_ts_96, 96'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("first_edge", output_ts_96, ts(48'd0, 30'd6, 16'h6666));
        repeat (9) tick();
        check_eq("ten_edges", output_ts_96, ts(48'd0, 30'd63, 16'hFFFC));

        // Switch to 4.0 ns; the strobe edge still uses 6.4 ns.
        input_period_ns    = 4'd4;
        input_period_fns   = 16'd0;
        input_period_valid = 1'b1;
        tick();
        input_period_valid = 1'b0;
        check_eq("period_edge", output_ts_96, ts(48'd0, 30'd70, 16'h6662));
        tick();
        check_eq("period_used", output_ts_96, ts(48'd0, 30'd74, 16'h6662));

        input_ts_96       = ts(48'd5, 30'd999_999_998, 16'd0);
        input_ts_96_valid = 1'b1;
        tick();
        input_ts_96_valid = 1'b0;
        check_eq("load_ts", output_ts_96, ts(48'd5, 30'd999_999_998, 16'd0));
        check_flags("load", 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("rollover_ts", output_ts_96, ts(48'd6, 30'd2, 16'd0));
        check_flags("rollover", 1'b0, pps_exp, 1'b0);
        tick();
        check_eq("after_roll_ts", output_ts_96, ts(48'd6, 30'd6, 16'd0));
        check_flags("after_roll", 1'b0, 1'b0, 1'b0);

        // Slew +1.0 ns for 3 cycles.
        input_adj       = 21'h01_0000;
        input_adj_count = 16'd3;
        input_adj_valid = 1'b1;
        tick();
        input_adj_valid = 1'b0;
        check_eq("adj_cap_ts", output_ts_96, ts(48'd6, 30'd10, 16'd0));
        check_flags("adj_cap", 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("adj_a_ts", output_ts_96, ts(48'd6, 30'd15, 16'd0));
        check_flags("adj_a", 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("adj_b_ts", output_ts_96, ts(48'd6, 30'd20, 16'd0));
        check_flags("adj_b", 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("adj_c_ts", output_ts_96, ts(48'd6, 30'd25, 16'd0));
        check_flags("adj_c", 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("adj_done_ts", output_ts_96, ts(48'd6, 30'd29, 16'd0));

        // Slew -5.0 ns for 2 cycles: net negative, time must hold.
        input_adj       = 21'h1B_0000;
        input_adj_count = 16'd2;
        input_adj_valid = 1'b1;
        tick();
        input_adj_valid = 1'b0;
        check_eq("neg_cap_ts", output_ts_96, ts(48'd6, 30'd33, 16'd0));
        tick();
        check_eq("neg_hold1_ts", output_ts_96, ts(48'd6, 30'd33, 16'd0));
        check_flags("neg_hold1", 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("neg_hold2_ts", output_ts_96, ts(48'd6, 30'd33, 16'd0));
        check_flags("neg_hold2", 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("neg_done_ts", output_ts_96, ts(48'd6, 30'd37, 16'd0));

        input_ts_96       = ts(48'd9, 30'd1_000_000_000, 16'd0);
        input_ts_96_valid = 1'b1;
        tick();
        input_ts_96_valid = 1'b0;
        check_eq("bad_load_ts", output_ts_96, ts(48'd6, 30'd41, 16'd0));
        check_flags("bad_load", 1'b0, 1'b0, 1'b0);

        // Load and slew strobe together.
        input_ts_96       = ts(48'd100, 30'd500, 16'd0);
        input_ts_96_valid = 1'b1;
        input_adj         = 21'h01_0000;
        input_adj_count   = 16'd1;
        input_adj_valid   = 1'b1;
        tick();
        input_ts_96_valid = 1'b0;
        input_adj_valid   = 1'b0;
        check_eq("load_adj_ts", output_ts_96, ts(48'd100, 30'd500, 16'd0));
        check_flags("load_adj", 1'b1, 1'b0, 1'b1);
        tick();
        check_eq("load_adj_a_ts", output_ts_96, ts(48'd100, 30'd505, 16'd0));
        check_flags("load_adj_a", 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("load_adj_b_ts", output_ts_96, ts(48'd100, 30'd509, 16'd0));

        // Async reset between edges while a slew is running.
        input_adj       = 21'h01_0000;
        input_adj_count = 16'd5;
        input_adj_valid = 1'b1;
        tick();
        input_adj_valid = 1'b0;
        check_flags("pre_rst", 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_ts", output_ts_96, 96'd0);
        check_flags("async_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_eq("rerun_ts", output_ts_96, ts(48'd0, 30'd6, 16'h6666));
        check_flags("rerun", 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
